// File: rtl/fractal_sync_mp_cnt_rf.sv
// rtl/fractal_sync_mp_cnt_rf.sv - multi-port arrival counter register file with per-entry thresholds
// Optional: define FRACTAL_SYNC_CNT_RF_PERF_EN to add the perf_cnt_o completion counter.
module fractal_sync_mp_cnt_rf #(
    parameter int N_REGS      = 4,
    parameter int IDX_WIDTH   = 2,
    parameter int N_PORTS     = 4,
    parameter int CNT_WIDTH   = 4,
    parameter int DEFAULT_THR = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [N_PORTS-1:0]             req_valid_i,
    input  logic [N_PORTS*IDX_WIDTH-1:0]   req_idx_i,
    output logic [N_PORTS-1:0]             req_ready_o,
    input  logic                           cfg_we_i,
    input  logic [IDX_WIDTH-1:0]           cfg_idx_i,
    input  logic [CNT_WIDTH-1:0]           cfg_thr_i,
    output logic [N_REGS-1:0]              done_o,
    output logic [N_REGS-1:0]              busy_o,
    output logic [N_REGS-1:0]              err_o,
    output logic                           oor_err_o
`ifdef FRACTAL_SYNC_CNT_RF_PERF_EN
    ,
    output logic [31:0]                    perf_cnt_o
`endif
);

    if ((2 ** IDX_WIDTH) < N_REGS) begin : g_idx_width_chk
        $fatal(1, "IDX_WIDTH too small for N_REGS");
    end
    if (CNT_WIDTH < $clog2(N_PORTS + 1)) begin : g_cnt_width_chk
        $fatal(1, "CNT_WIDTH too small for N_PORTS");
    end

    localparam logic [IDX_WIDTH:0]   NREGS_W   = (IDX_WIDTH + 1)'(N_REGS);
    localparam logic [CNT_WIDTH-1:0] DEF_THR_W = CNT_WIDTH'(DEFAULT_THR);

    logic [CNT_WIDTH-1:0] cnt_q [N_REGS];
    logic [CNT_WIDTH-1:0] thr_q [N_REGS];
    logic [N_REGS-1:0]    done_q;
    logic [N_REGS-1:0]    err_q;
    logic                 oor_q;

    logic [CNT_WIDTH-1:0] inc   [N_REGS];
    logic [CNT_WIDTH:0]   sum   [N_REGS];
    logic                 req_oor;
    logic                 cfg_oor;

    // A cfg write stalls only the ports aiming at the entry being rewritten.
    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            req_ready_o[p] = !(cfg_we_i && (cfg_idx_i == req_idx_i[p*IDX_WIDTH +: IDX_WIDTH]));
        end
    end

    always_comb begin
        req_oor = 1'b0;
        for (int e = 0; e < N_REGS; e++) begin
            inc[e] = '0;
        end
        for (int p = 0; p < N_PORTS; p++) begin
            if (req_valid_i[p] && req_ready_o[p]) begin
                if ({1'b0, req_idx_i[p*IDX_WIDTH +: IDX_WIDTH]} >= NREGS_W) begin
                    req_oor = 1'b1;
                end
                for (int e = 0; e < N_REGS; e++) begin
                    if (req_idx_i[p*IDX_WIDTH +: IDX_WIDTH] == IDX_WIDTH'(e)) begin
                        inc[e] = inc[e] + CNT_WIDTH'(1);
                    end
                end
            end
        end
        // One extra bit so an overshooting arrival burst cannot wrap below thr.
        for (int e = 0; e < N_REGS; e++) begin
            sum[e] = {1'b0, cnt_q[e]} + {1'b0, inc[e]};
        end
    end

    assign cfg_oor = cfg_we_i && ({1'b0, cfg_idx_i} >= NREGS_W);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int e = 0; e < N_REGS; e++) begin
                cnt_q[e] <= '0;
                thr_q[e] <= DEF_THR_W;
            end
            done_q <= '0;
            err_q  <= '0;
            oor_q  <= 1'b0;
        end else begin
            if (req_oor || cfg_oor) begin
                oor_q <= 1'b1;
            end
            for (int e = 0; e < N_REGS; e++) begin
                if (cfg_we_i && (cfg_idx_i == IDX_WIDTH'(e))) begin
                    thr_q[e]  <= cfg_thr_i;
                    cnt_q[e]  <= '0;
                    err_q[e]  <= 1'b0;
                    done_q[e] <= 1'b0;
                end else begin
                    done_q[e] <= 1'b0;
                    if (thr_q[e] == '0) begin
                        if (inc[e] != '0) begin
                            err_q[e] <= 1'b1;
                        end
                    end else if (sum[e] >= {1'b0, thr_q[e]}) begin
                        cnt_q[e]  <= '0;
                        done_q[e] <= 1'b1;
                        if (sum[e] > {1'b0, thr_q[e]}) begin
                            err_q[e] <= 1'b1;
                        end
                    end else begin
                        cnt_q[e] <= sum[e][CNT_WIDTH-1:0];
                    end
                end
            end
        end
    end

    always_comb begin
        for (int e = 0; e < N_REGS; e++) begin
            busy_o[e] = (cnt_q[e] != '0);
        end
    end

    assign done_o    = done_q;
    assign err_o     = err_q;
    assign oor_err_o = oor_q;

`ifdef FRACTAL_SYNC_CNT_RF_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_q + 32'($countones(done_q));
        end
    end

    assign perf_cnt_o = perf_q;
`endif

endmodule

// File: doc/fractal_sync_mp_cnt_rf.md
FRACTAL_SYNC_MP_CNT_RF -- requirements
Module: fractal_sync_mp_cnt_rf

Interface
REQ-001 SHALL have parameter N_REGS, default 4: number of counter entries.
REQ-002 SHALL have parameter IDX_WIDTH, default 2: entry index width; 2**IDX_WIDTH >= N_REGS, otherwise elaboration fatal.
REQ-003 SHALL have parameter N_PORTS, default 4: number of arrival ports.
REQ-004 SHALL have parameter CNT_WIDTH, default 4: counter/threshold width; CNT_WIDTH >= $clog2(N_PORTS+1), otherwise elaboration fatal.
REQ-005 SHALL have parameter DEFAULT_THR, default 2: threshold loaded into every entry at reset.
REQ-006 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-007 rst_i  in  1  reset, synchronous, active-high.
REQ-008 req_valid_i  in  [N_PORTS] x 1  arrival request per port.
REQ-009 req_idx_i  in  [N_PORTS] x IDX_WIDTH  target entry per port.
REQ-010 req_ready_o  out  [N_PORTS] x 1  arrival accepted when valid and ready are both high.
REQ-011 cfg_we_i  in  1  threshold write strobe.
REQ-012 cfg_idx_i  in  IDX_WIDTH  entry written.
REQ-013 cfg_thr_i  in  CNT_WIDTH  new threshold.
REQ-014 done_o  out  N_REGS  one-cycle completion pulse per entry.
REQ-015 busy_o  out  N_REGS  entry counter non-zero.
REQ-016 err_o  out  N_REGS  sticky per-entry error.
REQ-017 oor_err_o  out  1  sticky out-of-range index error.

Function
REQ-018 Each entry SHALL hold cnt (CNT_WIDTH), thr (CNT_WIDTH), done flop, err flop.
REQ-019 req_ready_o[p] SHALL be combinational: low iff cfg_we_i=1 and cfg_idx_i==req_idx_i[p]; otherwise high.
REQ-020 inc[e] SHALL be the number of ports p with req_valid_i[p] and req_ready_o[p] and req_idx_i[p]==e in the same cycle (0..N_PORTS).
REQ-021 If thr[e]!=0 and cnt[e]+inc[e] < thr[e], the entry SHALL set cnt[e] <= cnt[e]+inc[e], with the sum computed one bit wider than CNT_WIDTH.
REQ-022 If thr[e]!=0 and cnt[e]+inc[e] >= thr[e], the entry SHALL set cnt[e] <= 0 and done_o[e] <= 1 in the next cycle.
REQ-023 If cnt[e]+inc[e] > thr[e] (excess arrivals in the completing cycle), the entry SHALL drop the excess and set err_o[e] <= 1.
REQ-024 If thr[e]==0 and inc[e]>0, the entry SHALL leave cnt[e] unchanged, SHALL NOT pulse done_o[e], and SHALL set err_o[e] <= 1.
REQ-025 done_o[e] SHALL be high for exactly one cycle per completion; back-to-back completions SHALL give pulses on consecutive cycles.
REQ-026 A cfg write SHALL set thr[cfg_idx_i] <= cfg_thr_i, cnt <= 0, err <= 0 and done <= 0 for that entry; it wins over arrivals to the same entry.
REQ-027 busy_o[e] SHALL equal (cnt[e]!=0), taken from registered state.
REQ-028 A valid request with req_idx_i >= N_REGS SHALL be accepted (ready high), SHALL have no entry effect, and SHALL set oor_err_o <= 1.
REQ-029 A cfg write with cfg_idx_i >= N_REGS SHALL be ignored and SHALL set oor_err_o <= 1.
REQ-030 oor_err_o SHALL be cleared only by reset.
REQ-031 Entries SHALL update independently in the same cycle; no cross-entry priority exists.

Reset
REQ-032 While rst_i is high at a clock edge, all cnt SHALL load 0, all thr SHALL load DEFAULT_THR, and done_o, err_o and oor_err_o SHALL load 0.
REQ-033 Arrivals and cfg writes in a reset cycle SHALL be discarded; partial counts SHALL be lost with no done pulse.
REQ-034 req_ready_o SHALL follow REQ-019 during reset.

Configuration
REQ-035 With FRACTAL_SYNC_CNT_RF_PERF_EN defined, the module SHALL add output perf_cnt_o (32 bits) counting the total number of done pulses across all entries (a popcount per cycle), wrapping at 2**32 and reset to 0.
REQ-036 Without FRACTAL_SYNC_CNT_RF_PERF_EN, perf_cnt_o and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-037 Ports 0 and 1 send valid to entry 2 in the same cycle, with thr=2 -> done_o[2] pulses next cycle for 1 cycle; cnt[2]=0; busy_o[2]=0.
REQ-038 Port 0 sends valid to entry 1 at cycle 0 and port 3 sends valid to entry 1 at cycle 5, with thr=2 -> busy_o[1]=1 in cycles 1..5; done_o[1] pulses at cycle 6.
REQ-039 cfg writes thr=3 to entry 0 while ports 0..2 target entry 0 -> req_ready_o[0..2]=0; thr[0]=3; cnt[0]=0; no done pulse.
REQ-040 Four ports target entry 3, with thr=2 -> done_o[3] pulses; err_o[3]=1 and stays set until a cfg write to entry 3.
REQ-041 Entry 1 has thr=0 and receives an arrival -> no done pulse; err_o[1]=1. A request with idx beyond N_REGS-1 (when N_REGS=3) -> oor_err_o=1.
REQ-042 rst_i is asserted with cnt[2]=1 -> cnt[2]=0, thr[2]=DEFAULT_THR, and no done pulse. With FRACTAL_SYNC_CNT_RF_PERF_EN defined, perf_cnt_o=0 after reset and 5 after five completions.
